apb_xfer_sequencer: RTL and testbench
=====================================

// Module: apb_xfer_sequencer
// PURPOSE
//  APB master-phase sequencer for the AXI-APB bridge. Consumes the one-hot
//  w_grant/r_grant from the read/write arbiter and runs one APB transfer
//  (SETUP -> ACCESS -> wait states) on the granted channel.
//  Selects the granted channel's address/data and drives the APB master pins.
//  Returns read data and error, and pulses done so the arbiter can re-arbitrate.
// PARAMETERS
//  ADDR_W   32  APB address width
//  DATA_W   32  APB data width (multiple of 8)
//  TIMEOUT  16  max ACCESS-phase PCLK cycles before forced error; 0 = disabled
// PORTS
//  clk       in   1         system clock (single clock domain)
//  reset     in   1         asynchronous, active-high reset
//  p_clk_en  in   1         PCLK-rate enable; all state advances only when 1
//  w_grant   in   1         write channel granted (from arbiter)
//  r_grant   in   1         read channel granted (from arbiter)
//  w_addr    in   ADDR_W    write address
//  w_data    in   DATA_W    write data
//  w_strb    in   DATA_W/8  write byte strobes
//  w_prot    in   3         write protection attributes
//  r_addr    in   ADDR_W    read address
//  r_prot    in   3         read protection attributes
//  paddr     out  ADDR_W    APB PADDR
//  psel      out  1         APB PSEL
//  penable   out  1         APB PENABLE
//  pwrite    out  1         APB PWRITE
//  pwdata    out  DATA_W    APB PWDATA (0 on reads)
//  pstrb     out  DATA_W/8  APB PSTRB (0 on reads)
//  pprot     out  3         APB PPROT
//  pready    in   1         APB PREADY
//  prdata    in   DATA_W    APB PRDATA
//  pslverr   in   1         APB PSLVERR
//  rsp_rdata out  DATA_W    captured read data (0 for writes / timeout)
//  rsp_err   out  1         captured PSLVERR or timeout error
//  done      out  1         transfer complete; high for exactly one PCLK cycle
//  busy      out  1         state != IDLE
// BEHAVIOUR
//  Reset: every output and internal register is 0; state = IDLE. Reset
//   applies immediately, including mid-transfer (psel/penable drop at once).
//  Transitions occur only on clk edges with p_clk_en=1; otherwise all hold.
//  FSM:
//   IDLE:   w_grant -> SETUP, pwrite=1, latch w_addr/w_data/w_strb/w_prot;
//           else r_grant -> SETUP, pwrite=0, latch r_addr/r_prot,
//           pwdata=0, pstrb=0. Write wins if both are high (illegal input).
//   SETUP:  -> ACCESS unconditionally; timeout counter cleared to 0.
//   ACCESS: pready=1 -> DONE; rsp_err=pslverr; rsp_rdata=prdata if read,
//           else 0. Else if TIMEOUT!=0 and cnt==TIMEOUT-1 -> DONE, rsp_err=1,
//           rsp_rdata=0. Else cnt++ (width $clog2(TIMEOUT+1), no wrap).
//   DONE:   -> IDLE. A grant seen in DONE is ignored until IDLE.
//  Outputs are decoded from registered state only: psel=SETUP|ACCESS,
//   penable=ACCESS, done=DONE, busy=!IDLE. paddr/pwrite/pwdata/pstrb/pprot
//   are stable from SETUP through ACCESS; they hold their values in DONE/IDLE.
//  rsp_rdata/rsp_err are valid while done=1 and hold until the next capture.
//  Grant dropping mid-transfer is ignored; an APB transfer is never aborted.
//  Min latency: grant in IDLE -> done is 3 PCLK edges (SETUP, ACCESS, DONE).
//   Back-to-back transfers therefore have one IDLE cycle between them.
// TESTING
//  Write, no wait: w_grant, w_addr=0x100, w_data=0xDEADBEEF, pready=1 ->
//   SETUP psel=1 penable=0 pwrite=1; ACCESS penable=1; done=1, rsp_err=0.
//  Read, 3 wait states: r_grant, r_addr=0x40, pready low 3 cycles,
//   prdata=0x12345678 -> done=1 after 6 PCLK edges, rsp_rdata=0x12345678.
//  Timeout: TIMEOUT=4, pready held 0 -> done after exactly 4 ACCESS cycles,
//   rsp_err=1, rsp_rdata=0, psel=0 afterwards.
//  p_clk_en = 1 every 3rd clk -> state, psel and penable change only on
//   enabled edges; done stays high for exactly 3 clk cycles.
//  Reset mid-ACCESS -> psel=penable=done=busy=0 immediately, no done pulse;
//   next grant starts cleanly from SETUP.
//  pslverr=1 with pready on a write -> rsp_err=1; both grants high in IDLE ->
//   pwrite=1.

Source files
------------

// File: rtl/apb_xfer_sequencer.sv
// APB master-phase sequencer: runs one SETUP/ACCESS transfer on the granted
// channel and returns read data and error status with a one-PCLK done pulse.
module apb_xfer_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p_clk_en,
  input  logic                w_grant,
  input  logic                r_grant,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic [2:0]          w_prot,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic [2:0]          r_prot,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                done,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  // The timeout check is compiled away when TIMEOUT is 0.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Next-state logic; grants are only looked at in IDLE so a transfer is never aborted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (w_grant || r_grant) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, advancing only on PCLK-enabled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (p_clk_en) begin
      state <= state_next;
    end
  end

  // Request capture, wait-state counter and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else if (p_clk_en) begin
      case (state)
        IDLE: begin
          // Write takes priority if the arbiter ever raises both grants.
          if (w_grant) begin
            paddr  <= w_addr;
            pwrite <= 1'b1;
            pwdata <= w_data;
            pstrb  <= w_strb;
            pprot  <= w_prot;
          end else if (r_grant) begin
            paddr  <= r_addr;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
            pprot  <= r_prot;
          end
        end
        SETUP: cnt <= '0;
        ACCESS: begin
          if (pready) begin
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (timeout_hit) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);
  assign done    = (state == DONE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// Self-checking bench for apb_xfer_sequencer with a transaction-level model.
module tb_apb_xfer_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, p_clk_en, w_grant, r_grant;
  logic [31:0] w_addr, w_data, r_addr, paddr, pwdata, prdata, rsp_rdata;
  logic [3:0]  w_strb, pstrb;
  logic [2:0]  w_prot, r_prot, pprot;
  logic        psel, penable, pwrite, pready, pslverr, rsp_err, done, busy;

  int checks = 0;
  int errors = 0;
  int div = 1;
  int done_clks;
  logic e_psel = 1'b0, e_pen = 1'b0, e_done = 1'b0, e_busy = 1'b0;

  apb_xfer_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .p_clk_en(p_clk_en),
    .w_grant(w_grant), .r_grant(r_grant),
    .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb), .w_prot(w_prot),
    .r_addr(r_addr), .r_prot(r_prot),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // One PCLK step: div-1 disabled clk edges (outputs must hold), then one enabled edge.
  task automatic pedge();
    for (int i = 1; i < div; i++) begin
      p_clk_en = 1'b0;
      @(posedge clk); #1;
      if (done) done_clks++;
      checks++;
      if ({psel, penable, done, busy} !== {e_psel, e_pen, e_done, e_busy}) begin
        errors++;
        $display("FAIL hold_disabled ctl got=%b exp=%b", {psel, penable, done, busy},
                 {e_psel, e_pen, e_done, e_busy});
      end
    end
    p_clk_en = 1'b1;
    @(posedge clk); #1;
    p_clk_en = 1'b0;
    if (done) done_clks++;
  endtask

  // Runs one transfer and checks every PCLK step against the transaction model.
  task automatic run_xfer(input bit wr, input bit both, input int waits, input bit serr,
                          input bit hold, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdat);
    logic        exp_wr, e_err;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_strb;
    logic [2:0]  e_prot;
    int          n;
    exp_wr  = wr | both;
    w_grant = wr | both;
    r_grant = !wr | both;
    w_strb  = 4'($urandom);
    w_prot  = 3'($urandom);
    r_prot  = 3'($urandom);
    if (exp_wr) begin
      w_addr = addr; w_data = data; r_addr = $urandom;
    end else begin
      r_addr = addr; w_addr = $urandom; w_data = $urandom;
    end
    pready  = 1'b0;
    e_addr  = addr;
    e_wdata = exp_wr ? data : 32'h0;
    e_strb  = exp_wr ? w_strb : 4'h0;
    e_prot  = exp_wr ? w_prot : r_prot;
    n       = (waits >= TO) ? 2 + TO : 3 + waits;
    e_err   = (waits >= TO) ? 1'b1 : serr;
    e_rd    = (waits >= TO || exp_wr) ? 32'h0 : rdat;
    done_clks = 0;
    for (int k = 1; k <= n + 1; k++) begin
      pready  = (k == 3 + waits) && (k <= n);
      pslverr = pready ? serr : 1'($urandom);
      prdata  = pready ? rdat : $urandom;
      pedge();
      if (k == 1 && !hold) begin
        w_grant = 1'b0; r_grant = 1'b0;
      end
      if (k < n) begin
        e_psel = 1'b1; e_pen = (k >= 2); e_done = 1'b0; e_busy = 1'b1;
      end else if (k == n) begin
        e_psel = 1'b0; e_pen = 1'b0; e_done = 1'b1; e_busy = 1'b1;
      end else begin
        e_psel = 1'b0; e_pen = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      end
      checks++;
      if ({psel, penable, done, busy} !== {e_psel, e_pen, e_done, e_busy}) begin
        errors++;
        $display("FAIL ctl step=%0d got=%b exp=%b", k, {psel, penable, done, busy},
                 {e_psel, e_pen, e_done, e_busy});
      end
      checks++;
      if ({paddr, pwrite, pwdata, pstrb, pprot} !== {e_addr, exp_wr, e_wdata, e_strb, e_prot}) begin
        errors++;
        $display("FAIL apb_pins step=%0d got=%h/%b/%h/%h/%h exp=%h/%b/%h/%h/%h", k,
                 paddr, pwrite, pwdata, pstrb, pprot, e_addr, exp_wr, e_wdata, e_strb, e_prot);
      end
      if (k >= n) begin
        checks++;
        if ({rsp_err, rsp_rdata} !== {e_err, e_rd}) begin
          errors++;
          $display("FAIL rsp step=%0d got err=%b rdata=%h exp err=%b rdata=%h", k,
                   rsp_err, rsp_rdata, e_err, e_rd);
        end
      end
    end
    pready = 1'b0;
    checks++;
    if (done_clks != div) begin
      errors++;
      $display("FAIL done_width got=%0d exp=%0d", done_clks, div);
    end
    $display("xfer wr=%0b both=%0b waits=%0d serr=%0b div=%0d addr=%h rsp_err=%b rsp_rdata=%h",
             wr, both, waits, serr, div, addr, rsp_err, rsp_rdata);
  endtask

  task automatic test_reset();
    reset = 1'b1; p_clk_en = 1'b0; w_grant = 1'b0; r_grant = 1'b0;
    w_addr = '0; w_data = '0; w_strb = '0; w_prot = '0; r_addr = '0; r_prot = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({paddr, psel, penable, pwrite, pwdata, pstrb, pprot, rsp_rdata, rsp_err, done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state paddr=%h psel=%b pen=%b done=%b busy=%b", paddr, psel, penable, done, busy);
    end
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_write_nowait();
    div = 1;
    run_xfer(1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0);
  endtask

  task automatic test_read_waits();
    div = 1;
    run_xfer(1'b0, 1'b0, 3, 1'b0, 1'b0, 32'h40, 32'h0, 32'h12345678);
  endtask

  task automatic test_timeout();
    div = 1;
    run_xfer(1'b0, 1'b0, 10, 1'b0, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D);
    run_xfer(1'b1, 1'b0, TO, 1'b0, 1'b0, 32'h84, 32'h55AA55AA, 32'h0);
  endtask

  task automatic test_clk_en();
    div = 3;
    run_xfer(1'b1, 1'b0, 1, 1'b0, 1'b0, 32'h200, 32'h0BADF00D, 32'h0);
    run_xfer(1'b0, 1'b0, 2, 1'b0, 1'b0, 32'h204, 32'h0, 32'h87654321);
    div = 1;
  endtask

  task automatic test_slverr_both();
    div = 1;
    run_xfer(1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h300, 32'h11112222, 32'h0);
    run_xfer(1'b0, 1'b1, 1, 1'b0, 1'b0, 32'h304, 32'h33334444, 32'h99998888);
  endtask

  task automatic test_back_to_back();
    div = 1;
    run_xfer(1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0);
    run_xfer(1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h404, 32'h0, 32'h5A5A5A5A);
    run_xfer(1'b1, 1'b0, 2, 1'b1, 1'b0, 32'h408, 32'h01020304, 32'h0);
  endtask

  task automatic test_reset_mid();
    div = 1;
    w_grant = 1'b1; r_grant = 1'b0; w_addr = 32'h500; w_data = 32'hFFFF0000;
    w_strb = 4'hF; w_prot = 3'h2; pready = 1'b0;
    pedge();
    w_grant = 1'b0;
    pedge();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_access got=%b exp=11", {psel, penable});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({psel, penable, done, busy, paddr} !== '0) begin
      errors++;
      $display("FAIL async_reset psel=%b pen=%b done=%b busy=%b paddr=%h", psel, penable, done, busy, paddr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    e_psel = 1'b0; e_pen = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pedge();
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_idle got=%b exp=00", {done, busy});
      end
    end
    pready = 1'b0;
    $display("reset mid-access handled");
    run_xfer(1'b0, 1'b0, 1, 1'b0, 1'b0, 32'h504, 32'h0, 32'h13579BDF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      div = int'($urandom_range(1, 3));
      run_xfer(1'($urandom), 1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 6)),
               1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
    end
    div = 1;
    // Final transfer without hold so the grants end low.
    run_xfer(1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h600, 32'h600DCAFE, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_nowait();
    test_read_waits();
    test_timeout();
    test_clk_en();
    test_slverr_both();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
